// File: rtl/truth_table_sweeper_if.sv
// Handshake and vector bus between the truth-table sweeper (master) and the
// host / logic under test (slave).
interface truth_table_sweeper_if #(
  parameter int N = 3
);
  logic         start;
  logic         abort;
  logic         z;
  logic [N-1:0] x;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_cnt;
  logic [N-1:0] first_fail;
  logic         first_valid;

  modport master (
    input  start,
    input  abort,
    input  z,
    output x,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output first_fail,
    output first_valid
  );

  modport slave (
    output start,
    output abort,
    output z,
    input  x,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  first_fail,
    input  first_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks x through 0..2^N-1, holds each vector for
// SETTLE cycles, compares z against EXPECT and reports mismatch statistics.
module truth_table_sweeper #(
  parameter int                N      = 3,
  parameter int                SETTLE = 2,
  parameter logic [(1<<N)-1:0] EXPECT = 8'hE8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.master bus
);

  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [N-1:0]   X_LAST   = {N{1'b1}};
  localparam logic [N-1:0]   X_ONE    = N'(1);
  localparam logic [N:0]     ERR_ONE  = (N + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  x_r;
  logic          busy_r;
  logic          done_r;
  logic          pass_r;
  logic [N:0]    err_r;
  logic [N-1:0]  first_fail_r;
  logic          first_valid_r;

  logic          sample_s;
  logic          mismatch_s;
  logic          start_ok_s;

  // Sample strobe, compare result and start qualification
  always_comb begin
    sample_s   = 1'b0;
    mismatch_s = 1'b0;
    start_ok_s = 1'b0;
    if (state_r == ST_RUN) begin
      sample_s = (cnt_r == CNT_LAST);
    end else begin
      sample_s = 1'b0;
    end
    mismatch_s = sample_s && (bus.z != EXPECT[x_r]);
    case (state_r)
      ST_IDLE: start_ok_s = bus.start;
      // the cycle carrying the done pulse must not retrigger a sweep
      ST_DONE: start_ok_s = bus.start && !done_r;
      default: start_ok_s = 1'b0;
    endcase
  end

  // Sweep state machine with registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      x_r           <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      err_r         <= '0;
      first_fail_r  <= '0;
      first_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            state_r       <= ST_RUN;
            busy_r        <= 1'b1;
            x_r           <= '0;
            cnt_r         <= '0;
            err_r         <= '0;
            first_fail_r  <= '0;
            first_valid_r <= 1'b0;
            pass_r        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            // partial err_cnt / first_fail stay visible for debug
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            pass_r  <= 1'b0;
            x_r     <= '0;
            cnt_r   <= '0;
          end else if (sample_s) begin
            if (mismatch_s) begin
              err_r <= err_r + ERR_ONE;
              if (!first_valid_r) begin
                first_fail_r  <= x_r;
                first_valid_r <= 1'b1;
              end
            end
            cnt_r <= '0;
            if (x_r == X_LAST) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (err_r == '0) && !mismatch_s;
            end else begin
              x_r <= x_r + X_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          x_r     <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.x           = x_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.pass        = pass_r;
  assign bus.err_cnt     = err_r;
  assign bus.first_fail  = first_fail_r;
  assign bus.first_valid = first_valid_r;

endmodule
